// File: rtl/spi_adc_rx_pkg.sv
// spi_adc_rx_pkg: shared definitions for the multi-channel SPI ADC receiver.
// Holds the FSM state encoding, the default parameter set and the counter-width helper.
// No ports; imported by the interface, the top and the sclk prescaler.
package spi_adc_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_QUIET = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int DEF_NCH     = 2;
  localparam int DEF_DW      = 12;
  localparam int DEF_LEAD    = 4;
  localparam int DEF_FRAME   = 16;
  localparam int DEF_CLK_DIV = 2;
  localparam int DEF_QUIET   = 4;
  localparam int SEQ_W       = 8;

  // Bits needed to hold the values 0..n-1; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_adc_rx_multi_if.sv
// spi_adc_rx_multi_if: ADC pins plus control and sample handshake of the receiver.
// master = receiver side (drives sclk/ncs/data/valid/ovr/busy), slave = pins/consumer side.
// SPI_ADC_RX_SEQ_EN adds the 8-bit frame sequence number seq.
interface spi_adc_rx_multi_if #(
  parameter int NCH = spi_adc_rx_pkg::DEF_NCH,
  parameter int DW  = spi_adc_rx_pkg::DEF_DW
);
  logic [NCH-1:0]    sdata;
  logic              sclk;
  logic              ncs;
  logic              start;
  logic              cont;
  logic [NCH*DW-1:0] data;
  logic              valid;
  logic              ack;
  logic              ovr;
  logic              busy;
`ifdef SPI_ADC_RX_SEQ_EN
  logic [spi_adc_rx_pkg::SEQ_W-1:0] seq;
`endif

  modport master (
    input  sdata, start, cont, ack,
    output sclk, ncs, data, valid, ovr, busy
`ifdef SPI_ADC_RX_SEQ_EN
    , output seq
`endif
  );

  modport slave (
    output sdata, start, cont, ack,
    input  sclk, ncs, data, valid, ovr, busy
`ifdef SPI_ADC_RX_SEQ_EN
    , input seq
`endif
  );

endinterface

// File: rtl/spi_adc_clk_gen.sv
// spi_adc_clk_gen: CLK_DIV prescaler producing the sclk level and per-bit strobes while enabled.
// Latency: sclk low for CLK_DIV cycles then high for CLK_DIV cycles per bit; strobes are combinational.
// Backpressure: none; disabling clears the phase so the next enable starts on a fresh low half.
// Ports: clk, rst (sync, active high), en (SHIFT state), sclk (idles high),
//        sample (last low cycle: sdata captured on the 0->1 edge), bit_end (last high cycle of a bit).
module spi_adc_clk_gen
  import spi_adc_rx_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic sample,
  output logic bit_end
);
  localparam int W = idx_w(CLK_DIV);

  logic [W-1:0] div_cnt;
  logic         phase;   // 0 = low half of the bit, 1 = high half
  logic         last;

  assign last = (div_cnt == W'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      div_cnt <= '0;
      phase   <= 1'b0;
    end else if (last) begin
      div_cnt <= '0;
      phase   <= ~phase;
    end else begin
      div_cnt <= div_cnt + W'(1);
    end
  end

  assign sclk    = !en || phase;
  assign sample  = en && !phase && last;
  assign bit_end = en && phase && last;

endmodule

// File: rtl/spi_adc_rx_multi.sv
// spi_adc_rx_multi: NCH-lane SPI ADC receiver, shared sclk/ncs, single-shot or continuous conversion.
// Latency: DONE 1+CLK_DIV+2*CLK_DIV*FRAME+QUIET cycles after start; data/valid/ovr registered one cycle later.
// Backpressure: none toward the ADC; an unacknowledged set is overwritten and flagged by a one-cycle ovr.
// Ports: clk, rst (sync, active high), bus (spi_adc_rx_multi_if.master): sdata/sclk/ncs pins,
//        start/cont control, data/valid/ack/ovr handshake, busy. Needs LEAD+DW <= FRAME, DW >= 2.
// Optional macro SPI_ADC_RX_SEQ_EN: adds bus.seq, a frame number loaded alongside data (first set = 1).
module spi_adc_rx_multi
  import spi_adc_rx_pkg::*;
#(
  parameter int NCH     = DEF_NCH,
  parameter int DW      = DEF_DW,
  parameter int LEAD    = DEF_LEAD,
  parameter int FRAME   = DEF_FRAME,
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int QUIET   = DEF_QUIET
) (
  input  logic               clk,
  input  logic               rst,
  spi_adc_rx_multi_if.master bus
);
  localparam int CMAX0 = (FRAME > QUIET) ? FRAME : QUIET;
  localparam int CMAX  = (CMAX0 > CLK_DIV) ? CMAX0 : CLK_DIV;
  // One wider than the largest count so LEAD+DW == FRAME still fits in compares.
  localparam int CW    = idx_w(CMAX + 1);

  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt;     // SETUP/QUIET: clk cycles, SHIFT: bit index
  logic                   shift_en;
  logic                   sclk_lvl;
  logic                   sample;
  logic                   bit_end;
  logic                   in_win;
  logic [NCH-1:0][DW-1:0] sh;
  logic [NCH-1:0][DW-1:0] data_q;
  logic                   valid_q;
  logic                   ovr_q;

  assign shift_en = (state == ST_SHIFT);

  spi_adc_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk     (clk),
    .rst     (rst),
    .en      (shift_en),
    .sclk    (sclk_lvl),
    .sample  (sample),
    .bit_end (bit_end)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (bus.start || bus.cont)                  state_nxt = ST_SETUP;
      ST_SETUP: if (cnt == CW'(CLK_DIV - 1))                state_nxt = ST_SHIFT;
      ST_SHIFT: if (bit_end && (cnt == CW'(FRAME - 1)))     state_nxt = ST_QUIET;
      ST_QUIET: if (cnt == CW'(QUIET - 1))                  state_nxt = ST_DONE;
      ST_DONE:  state_nxt = bus.cont ? ST_SETUP : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        cnt <= '0;
      else if ((state == ST_SETUP) || (state == ST_QUIET) || ((state == ST_SHIFT) && bit_end))
        cnt <= cnt + CW'(1);
    end
  end

  // During SHIFT cnt is the index of the bit currently on the wire.
  assign in_win = (cnt >= CW'(LEAD)) && (cnt < CW'(LEAD + DW));

  always_ff @(posedge clk) begin
    if (rst) begin
      sh <= '0;
    end else if (sample && in_win) begin
      for (int i = 0; i < NCH; i++)
        sh[i] <= {sh[i][DW-2:0], bus.sdata[i]};
    end
  end

  // An ack landing in the DONE cycle is consumed by the new set, so valid stays up without ovr.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (state == ST_DONE) begin
        data_q  <= sh;
        valid_q <= 1'b1;
        ovr_q   <= valid_q && !bus.ack;
      end else if (bus.ack) begin
        valid_q <= 1'b0;
      end
    end
  end

`ifdef SPI_ADC_RX_SEQ_EN
  logic [SEQ_W-1:0] seq_q;

  always_ff @(posedge clk) begin
    if (rst)
      seq_q <= '0;
    else if (state == ST_DONE)
      seq_q <= seq_q + SEQ_W'(1);
  end

  assign bus.seq = seq_q;
`endif

  assign bus.sclk  = sclk_lvl;
  assign bus.ncs   = !((state == ST_SETUP) || (state == ST_SHIFT));
  assign bus.busy  = (state != ST_IDLE);
  assign bus.data  = data_q;
  assign bus.valid = valid_q;
  assign bus.ovr   = ovr_q;

endmodule

// File: doc/spi_adc_rx_multi.md
# spi_adc_rx_multi

Parametrised multi-channel SPI ADC receiver, the successor to the fixed two-channel, 12-bit Pmod ADC receiver. It drives one shared `sclk`/`ncs` pair and captures `NCH` serial data lines in parallel. It supports single-shot and continuous conversion and has a valid/ack output handshake with overrun detection. It sits between the Pmod ADC pins and the sample formatter that feeds the UART transmitter.

## Interface
- `NCH`, 2: number of ADC data lines (1–8)
- `DW`, 12: captured sample width per channel
- `LEAD`, 4: leading bits discarded per frame
- `FRAME`, 16: sclk cycles per conversion; `LEAD+DW <= FRAME` is required
- `CLK_DIV`, 2: clk cycles per sclk half-period (≥1)
- `QUIET`, 4: clk cycles `ncs` stays high after a frame (≥1)

Ports:
- `clk` in 1: system clock
- `rst` in 1: synchronous, active-high reset
- `sdata` in NCH: ADC serial data, bit i = channel i
- `sclk` out 1: SPI clock, idles high
- `ncs` out 1: ADC chip select, active low
- `start` in 1: begin conversion, sampled only in IDLE
- `cont` in 1: continuous mode request
- `data` out NCH*DW: samples, channel i at `[i*DW +: DW]`
- `valid` out 1: `data` holds an unacknowledged sample set
- `ack` in 1: consumer takes `data`, clears `valid`
- `ovr` out 1: one-cycle pulse when a new set overwrites an unacknowledged one
- `busy` out 1: high in every state except IDLE

## Operation
- States: IDLE → SETUP → SHIFT → QUIET → DONE → (IDLE, or SETUP if `cont`=1 in DONE).
- IDLE: `ncs`=1, `sclk`=1. Transition to SETUP when `start`=1 or `cont`=1.
- SETUP: `ncs`=0, `sclk`=1 for CLK_DIV cycles.
- SHIFT: FRAME bits. Each bit is `sclk`=0 for CLK_DIV cycles, then `sclk`=1 for CLK_DIV cycles. `sdata` is sampled on the clk edge where `sclk` goes 0→1.
  - Bits 0..LEAD-1 are discarded.
  - Bits LEAD..LEAD+DW-1 shift MSB-first into per-channel shift registers.
  - Remaining bits are ignored.
- QUIET: `ncs`=1, `sclk`=1 for QUIET cycles.
- DONE (1 cycle): `data` is loaded from the shift registers and `valid` is set.
  - If `valid` was already 1 and `ack`=0 this cycle, `ovr` pulses.
  - If `ack`=1 in the same cycle, there is no overrun and `valid` stays 1 with the new data.
- `ack` clears `valid` in any state other than the DONE case above. `ack` with `valid`=0 is ignored.
- `start` while `busy`=1 is ignored. There is no queuing.
- Dropping `cont` mid-frame completes the current frame, then the block goes to IDLE.
- `data` is stable between DONE cycles regardless of `ack`.

## Timing
- Reset values: `sclk`=1, `ncs`=1, `data`=0, `valid`=0, `ovr`=0, `busy`=0, state IDLE, all counters 0.
- `rst` mid-frame aborts immediately: `ncs` goes high on the next edge and the partial sample is discarded.
- Latency: DONE occurs L = 1 + CLK_DIV + 2·CLK_DIV·FRAME + QUIET cycles after the cycle in which `start` is sampled high in IDLE. With defaults, L = 71.
- Continuous frame period (DONE to DONE) = L. Minimum single-shot period = L+1.
- `ovr` and DONE-cycle updates are registered and visible the cycle after the DONE edge, together with `data`/`valid`.

## Configuration
- `SPI_ADC_RX_SEQ_EN` defined:
  - Adds output `seq` [7:0], a frame sequence number.
  - It increments at every DONE, wraps 255→0, resets to 0, and is loaded alongside `data`, so the value presented with the first set is 1.
- Undefined: no `seq` port and no counter logic.

## Structure
- Shared package/header `spi_adc_rx_pkg` holds:
  - state encoding constants (IDLE, SETUP, SHIFT, QUIET, DONE)
  - the default parameter values
  - the bit-index width function (clog2) used for the counters
- One sub-module, `spi_adc_clk_gen`:
  - CLK_DIV prescaler producing the `sclk` level and a one-cycle rising-edge sample strobe
  - enabled only in SHIFT
- Shift registers, FSM and handshake stay in the top.

## Test plan
- Defaults; ch0 returns 0x0ABC, ch1 0x0123 (16-bit frames, 4 leading zeros); one `start` pulse → DONE at cycle 71; `data`=0x123_ABC; `valid`=1; exactly 16 `sclk` low pulses; `ncs` low for 66 cycles.
- `cont`=1, `ack` held low across two frames → second DONE 71 cycles after first; `ovr` pulses once; `data` shows second sample.
- `cont`=1 with `ack` issued on the DONE cycle → no `ovr`; `valid` stays 1; each frame period is 71 cycles.
- `rst` asserted at cycle 30 of a frame → next cycle `ncs`=1, `sclk`=1, `busy`=0, `valid`=0; a later `start` yields a correct fresh sample.
- NCH=4, DW=10, LEAD=2, CLK_DIV=1; channel patterns 0x3FF, 0x000, 0x155, 0x2AA → `data` packed correctly; L = 1+1+32+4 = 38.
- `SPI_ADC_RX_SEQ_EN` defined; 257 continuous frames → `seq` goes 1..255, 0, 1.
